// File: rtl/plane_move.sv
// Plane motion and bird-drop sequencer: fixed-point horizontal travel with wrap,
// triangular vertical bob, and a drop/cooldown/ammo state machine.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, parked until the first frame pulse
// FLY      | moving, drops accepted when allowed
// DROP_REQ | showBird asserted, held through the next frame pulse
// COOLDOWN | counting frames before drops are allowed again
// EMPTY    | out of ammo, still moving, waiting for newGame
module plane_move #(
    parameter int INITIAL_X       = 0,
    parameter int PLANE_Y         = 40,
    parameter int PLANE_SPEED     = 128,
    parameter int X_MAX           = 575,
    parameter int DROP_X_LIMIT    = 285,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int NUM_BIRDS       = 5,
    parameter int BOB_AMPL        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        dropKey,
    input  logic        newGame,
    input  logic        birdActive,
    output logic [10:0] planeTopLeftX,
    output logic [10:0] planeTopLeftY,
    output logic [10:0] planeSpeed,
    output logic        showBird,
    output logic [2:0]  birdsLeft
);

    localparam int XW = 17;
    localparam logic [XW:0]      X_LIMIT_FP = (XW+1)'(X_MAX * 64);
    localparam logic [XW:0]      SPEED_FP   = (XW+1)'(PLANE_SPEED);
    localparam logic [XW-1:0]    X_INIT_FP  = XW'(INITIAL_X * 64);
    localparam logic signed [7:0] BOB_HI    = 8'(BOB_AMPL);
    localparam logic signed [7:0] BOB_LO    = 8'(-BOB_AMPL);

    typedef enum logic [2:0] {
        IDLE,
        FLY,
        DROP_REQ,
        COOLDOWN,
        EMPTY
    } state_t;

    state_t             state;
    logic [XW-1:0]      x_fp;
    logic signed [7:0]  bob_off;
    logic               bob_up;
    logic               drop_key_d;
    logic [15:0]        cool_cnt;

    logic [XW:0]        x_sum;
    logic [XW-1:0]      x_step;
    logic signed [7:0]  off_step;
    logic               drop_rise;
    logic               drop_ok;

    assign planeTopLeftX = x_fp[XW-1:6];
    assign planeSpeed    = 11'(PLANE_SPEED);

    always_comb begin
        x_sum     = {1'b0, x_fp} + SPEED_FP;
        x_step    = (x_sum > X_LIMIT_FP) ? '0 : x_sum[XW-1:0];
        off_step  = bob_up ? (bob_off + 8'sd1) : (bob_off - 8'sd1);
        drop_rise = dropKey & ~drop_key_d;
        drop_ok   = drop_rise & ~birdActive & (birdsLeft != 3'd0)
                    & (planeTopLeftX <= 11'(DROP_X_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            x_fp          <= X_INIT_FP;
            bob_off       <= 8'sd0;
            bob_up        <= 1'b1;
            planeTopLeftY <= 11'(PLANE_Y);
            showBird      <= 1'b0;
            birdsLeft     <= 3'(NUM_BIRDS);
            cool_cnt      <= '0;
            drop_key_d    <= 1'b0;
        end else begin
            drop_key_d <= dropKey;

            // Motion runs in every state but IDLE, independent of the drop sequence.
            if (startOfFrame && state != IDLE) begin
                x_fp          <= x_step;
                bob_off       <= off_step;
                planeTopLeftY <= 11'(PLANE_Y) + {{3{off_step[7]}}, off_step};
                if (off_step == BOB_HI || off_step == BOB_LO)
                    bob_up <= ~bob_up;
            end

            case (state)
                IDLE: begin
                    if (startOfFrame)
                        state <= FLY;
                end
                FLY: begin
                    if (drop_ok) begin
                        state     <= DROP_REQ;
                        showBird  <= 1'b1;
                        birdsLeft <= birdsLeft - 3'd1;
                    end
                end
                DROP_REQ: begin
                    if (startOfFrame) begin
                        state    <= COOLDOWN;
                        showBird <= 1'b0;
                        cool_cnt <= 16'(COOLDOWN_FRAMES);
                    end
                end
                COOLDOWN: begin
                    // A newGame arriving on the exit cycle refills ammo, so don't park in EMPTY.
                    if (cool_cnt == 16'd0)
                        state <= (birdsLeft != 3'd0 || newGame) ? FLY : EMPTY;
                    else if (startOfFrame)
                        cool_cnt <= cool_cnt - 16'd1;
                end
                EMPTY: begin
                    if (newGame)
                        state <= FLY;
                end
                default: state <= IDLE;
            endcase

            if (newGame)
                birdsLeft <= 3'(NUM_BIRDS);
        end
    end

endmodule

// File: tb/tb_plane_move.sv
// Randomised plus directed stimulus for plane_move; a frame-level reference model
// queues expected outputs and a separate monitor compares them each cycle.
module tb_plane_move;

    localparam int INITIAL_X       = 0;
    localparam int PLANE_Y         = 40;
    localparam int PLANE_SPEED     = 128;
    localparam int X_MAX           = 575;
    localparam int DROP_X_LIMIT    = 285;
    localparam int COOLDOWN_FRAMES = 30;
    localparam int NUM_BIRDS       = 5;
    localparam int BOB_AMPL        = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        dropKey = 1'b0;
    logic        newGame = 1'b0;
    logic        birdActive = 1'b0;
    logic [10:0] planeTopLeftX;
    logic [10:0] planeTopLeftY;
    logic [10:0] planeSpeed;
    logic        showBird;
    logic [2:0]  birdsLeft;

    always #5 clk = ~clk;

    plane_move #(
        .INITIAL_X(INITIAL_X), .PLANE_Y(PLANE_Y), .PLANE_SPEED(PLANE_SPEED),
        .X_MAX(X_MAX), .DROP_X_LIMIT(DROP_X_LIMIT), .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
        .NUM_BIRDS(NUM_BIRDS), .BOB_AMPL(BOB_AMPL)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .dropKey(dropKey),
        .newGame(newGame), .birdActive(birdActive), .planeTopLeftX(planeTopLeftX),
        .planeTopLeftY(planeTopLeftY), .planeSpeed(planeSpeed), .showBird(showBird),
        .birdsLeft(birdsLeft)
    );

    typedef struct {
        int x;
        int y;
        int show;
        int ammo;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: frames moved since reset, fixed-point X, and a few flags.
    bit m_moving;
    int m_frames;
    int m_xfp;
    int m_ammo;
    bit m_show;
    int m_cool;     // -1 when not cooling
    bit m_empty;
    bit m_prev;

    function automatic int tri_off(int n);
        int p;
        p = n % (4 * BOB_AMPL);
        if (p <= BOB_AMPL)          return p;
        else if (p <= 3 * BOB_AMPL) return 2 * BOB_AMPL - p;
        else                        return p - 4 * BOB_AMPL;
    endfunction

    task automatic model_step(input bit sof, input bit dk, input bit ng,
                              input bit ba, input bit rst);
        bit rise;
        int xpix;
        if (rst) begin
            m_moving = 0; m_frames = 0; m_xfp = INITIAL_X * 64; m_ammo = NUM_BIRDS;
            m_show = 0; m_cool = -1; m_empty = 0; m_prev = 0;
            return;
        end
        rise   = dk && !m_prev;
        m_prev = dk;
        xpix   = m_xfp / 64;
        if (!m_moving) begin
            if (sof) m_moving = 1;
        end else begin
            if (m_show) begin
                if (sof) begin m_show = 0; m_cool = COOLDOWN_FRAMES; end
            end else if (m_cool >= 0) begin
                if (m_cool == 0) begin
                    m_cool  = -1;
                    m_empty = (m_ammo == 0) && !ng;
                end else if (sof) begin
                    m_cool--;
                end
            end else if (m_empty) begin
                if (ng) m_empty = 0;
            end else if (rise && !ba && m_ammo > 0 && xpix <= DROP_X_LIMIT) begin
                m_show = 1;
                m_ammo--;
            end
            if (sof) begin
                m_xfp = m_xfp + PLANE_SPEED;
                if (m_xfp > X_MAX * 64) m_xfp = 0;
                m_frames++;
            end
        end
        if (ng) m_ammo = NUM_BIRDS;
    endtask

    task automatic cyc(input bit sof, input bit dk, input bit ng, input bit ba, input bit rst);
        exp_t e;
        @(posedge clk);
        #1;
        startOfFrame = sof; dropKey = dk; newGame = ng; birdActive = ba; reset = rst;
        model_step(sof, dk, ng, ba, rst);
        e.x    = m_xfp / 64;
        e.y    = PLANE_Y + tri_off(m_frames);
        e.show = m_show;
        e.ammo = m_ammo;
        q.push_back(e);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic press(input bit ba);
        cyc(0, 1, 0, ba, 0);
        cyc(0, 0, 0, ba, 0);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                @(negedge clk);
                chk("planeTopLeftX", int'(planeTopLeftX), e.x);
                chk("planeTopLeftY", int'(planeTopLeftY), e.y);
                chk("showBird",      int'(showBird),      e.show);
                chk("birdsLeft",     int'(birdsLeft),     e.ammo);
                chk("planeSpeed",    int'(planeSpeed),    PLANE_SPEED);
            end
        end
    end

    initial begin : stimulus
        int guard;
        repeat (3) cyc(0, 0, 0, 0, 1);
        frames(3);

        // Accepted drop near the left edge, then a second press inside cooldown.
        press(0);
        frames(5);
        press(0);
        frames(36);

        // Rejected with a bird already on screen.
        press(1);
        frames(2);

        // Accept, then reset while the request is pending.
        press(0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // Long flight past the drop window and through the wrap.
        frames(160);
        press(0);
        frames(150);

        // Spend all ammo, keep pressing while empty, then start a new game.
        guard = 0;
        while (m_ammo > 0 && guard < 60) begin
            press(0);
            frames(33);
            guard++;
        end
        frames(2);
        press(0);
        frames(3);
        cyc(0, 0, 1, 0, 0);
        frames(2);
        press(0);
        frames(4);

        // Randomised traffic including occasional reset and newGame.
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0) ? ~dropKey : dropKey,
                ($urandom_range(0, 1999) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2499) == 0));
        end

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
